// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, shifter modes
// and the bit positions of the packed N/Z/C/V flag register.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_NAND = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_OUT  = 4'd6,
        OP_IN   = 4'd7,
        OP_MOV  = 4'd8,
        OP_ASR  = 4'd9,
        OP_ADC  = 4'd10
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOGIC = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_mode_e;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_V    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: holds the working value, remaining count
// and shift mode; the top FSM loads it, steps it, and commits on 'last'.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  shift_mode_e        mode,
    input  logic [WIDTH-1:0]   load_data,
    input  logic [SHAMT_W-1:0] load_count,
    output logic [WIDTH-1:0]   next_data,
    output logic               out_bit,
    output logic               last
);

    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    shift_mode_e        mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            count  <= '0;
            mode_q <= SH_LEFT;
        end else if (load) begin
            work   <= load_data;
            count  <= load_count;
            mode_q <= mode;
        end else if (step) begin
            work   <= next_data;
            count  <= count - SHAMT_W'(1);
        end
    end

    // The value after one more shift and the bit that shift drops off the end.
    always_comb begin
        next_data = work;
        out_bit   = 1'b0;
        case (mode_q)
            SH_LEFT: begin
                next_data = {work[WIDTH-2:0], 1'b0};
                out_bit   = work[WIDTH-1];
            end
            SH_RIGHT_LOGIC: begin
                next_data = {1'b0, work[WIDTH-1:1]};
                out_bit   = work[0];
            end
            SH_RIGHT_ARITH: begin
                next_data = {work[WIDTH-1], work[WIDTH-1:1]};
                out_bit   = work[0];
            end
            default: begin
                next_data = work;
                out_bit   = 1'b0;
            end
        endcase
    end

    assign last = (count == SHAMT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake and multi-cycle shifts.
// Define ALU_SEQ_CARRY_EN to enable the C/V flags and the ADC opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic [WIDTH-1:0] result,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             busy,
    output logic             done
);

`ifdef ALU_SEQ_CARRY_EN
    localparam logic CARRY_EN = 1'b1;
`else
    localparam logic CARRY_EN = 1'b0;
`endif

    op_e                  op;
    state_e               state;
    state_e               next_state;
    logic [NUM_FLAGS-1:0] flags;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    shift_mode_e          sh_mode;
    logic                 sh_load;
    logic                 sh_step;
    logic                 sh_last;
    logic                 sh_out;
    logic [WIDTH-1:0]     sh_next;

    logic                 carry_in;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_upd;

    logic                 done_d;
    logic                 upd;
    logic [WIDTH-1:0]     upd_res;
    logic                 upd_c;
    logic                 upd_v;

    assign op       = op_e'(sel);
    assign shamt    = in_B[SHAMT_W-1:0];
    assign is_shift = is_shift_op(op);
    assign sh_mode  = (op == OP_SHR) ? SH_RIGHT_LOGIC :
                      (op == OP_ASR) ? SH_RIGHT_ARITH : SH_LEFT;
    assign carry_in = (op == OP_ADC) ? flags[FLAG_C] : 1'b0;

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .step       (sh_step),
        .mode       (sh_mode),
        .load_data  (in_A),
        .load_count (shamt),
        .next_data  (sh_next),
        .out_bit    (sh_out),
        .last       (sh_last)
    );

    // Single-cycle datapath; ops that do not update default to the held result.
    always_comb begin
        sum     = {1'b0, in_A} + {1'b0, in_B} + {{WIDTH{1'b0}}, carry_in};
        diff    = {1'b0, in_A} - {1'b0, in_B};
        alu_res = result;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                if (op == OP_ADD || CARRY_EN) begin
                    alu_res = sum[WIDTH-1:0];
                    alu_c   = sum[WIDTH];
                    alu_v   = (in_A[WIDTH-1] == in_B[WIDTH-1]) &&
                              (sum[WIDTH-1] != in_A[WIDTH-1]);
                    alu_upd = 1'b1;
                end
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (in_A[WIDTH-1] != in_B[WIDTH-1]) &&
                          (diff[WIDTH-1] != in_A[WIDTH-1]);
                alu_upd = 1'b1;
            end
            OP_NAND: begin
                alu_res = ~(in_A & in_B);
                alu_upd = 1'b1;
            end
            OP_OUT: begin
                alu_res = in_A;
                alu_upd = 1'b1;
            end
            OP_IN: begin
                alu_res = '0;
                alu_upd = 1'b1;
            end
            OP_MOV: begin
                alu_res = in_B;
                alu_upd = 1'b1;
            end
            default: begin
                alu_upd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is only looked at in IDLE, so requests during a shift are dropped.
    always_comb begin
        next_state = state;
        sh_load    = 1'b0;
        sh_step    = 1'b0;
        done_d     = 1'b0;
        upd        = 1'b0;
        upd_res    = '0;
        upd_c      = 1'b0;
        upd_v      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift && shamt != '0) begin
                        sh_load    = 1'b1;
                        next_state = ST_SHIFT;
                    end else if (is_shift) begin
                        done_d  = 1'b1;
                        upd     = 1'b1;
                        upd_res = in_A;
                    end else begin
                        done_d  = 1'b1;
                        upd     = alu_upd;
                        upd_res = alu_res;
                        upd_c   = alu_c;
                        upd_v   = alu_v;
                    end
                end
            end
            ST_SHIFT: begin
                sh_step = 1'b1;
                if (sh_last) begin
                    done_d     = 1'b1;
                    upd        = 1'b1;
                    upd_res    = sh_next;
                    upd_c      = sh_out;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_d;
            if (upd) begin
                result        <= upd_res;
                flags[FLAG_N] <= upd_res[WIDTH-1];
                flags[FLAG_Z] <= (upd_res == '0);
                flags[FLAG_C] <= upd_c & CARRY_EN;
                flags[FLAG_V] <= upd_v & CARRY_EN;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign N    = flags[FLAG_N];
    assign Z    = flags[FLAG_Z];
    assign C    = flags[FLAG_C];
    assign V    = flags[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed steps plus random ops against an
// arithmetic reference model. Honours ALU_SEQ_CARRY_EN when it is defined.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       sel;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [WIDTH-1:0] result;
    logic             N, Z, C, V;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    bit carry_en;
    int exp_res;
    bit exp_n, exp_z, exp_c, exp_v;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .in_A   (in_A),
        .in_B   (in_B),
        .result (result),
        .N      (N),
        .Z      (Z),
        .C      (C),
        .V      (V),
        .busy   (busy),
        .done   (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "/result"}, result, exp_res);
        checkOutput({tag, "/N"}, N, exp_n);
        checkOutput({tag, "/Z"}, Z, exp_z);
        checkOutput({tag, "/C"}, C, exp_c);
        checkOutput({tag, "/V"}, V, exp_v);
    endtask

    // Reference: what one operation does to result and flags, and its latency.
    function automatic void model(input int op, input int a, input int b,
                                  output bit upd, output int res, output bit c,
                                  output bit v, output int lat);
        int sa, sb, s, wide;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        s   = b % WIDTH;
        upd = 1'b1;
        res = 0;
        c   = 1'b0;
        v   = 1'b0;
        lat = 0;
        case (op)
            1: begin
                wide = a + b;
                res  = wide % 256;
                c    = (wide > 255);
                v    = (sa + sb > 127) || (sa + sb < -128);
            end
            2: begin
                res = (a - b + 256) % 256;
                c   = (a < b);
                v   = (sa - sb > 127) || (sa - sb < -128);
            end
            3: res = 255 - (a & b);
            4: begin
                res = (a << s) % 256;
                c   = (s > 0) && ((a >> (WIDTH - s)) % 2 == 1);
                lat = s;
            end
            5: begin
                res = a >> s;
                c   = (s > 0) && ((a >> (s - 1)) % 2 == 1);
                lat = s;
            end
            6: res = a;
            7: res = 0;
            8: res = b;
            9: begin
                res = (sa >>> s) & 255;
                c   = (s > 0) && ((a >> (s - 1)) % 2 == 1);
                lat = s;
            end
            10: begin
                if (carry_en) begin
                    wide = a + b + int'(exp_c);
                    res  = wide % 256;
                    c    = (wide > 255);
                    v    = (sa + sb + int'(exp_c) > 127) || (sa + sb + int'(exp_c) < -128);
                end else begin
                    upd = 1'b0;
                end
            end
            default: upd = 1'b0;
        endcase
        if (!carry_en) begin
            c = 1'b0;
            v = 1'b0;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge where done is checked.
    task automatic applyStimulus(input int op, input int a, input int b,
                                 input bit intrude, input string tag);
        bit upd, c, v;
        int res, lat;
        model(op, a, b, upd, res, c, v, lat);
        start = 1'b1;
        sel   = 4'(op);
        in_A  = 8'(a);
        in_B  = 8'(b);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            checkOutput({tag, "/busy"}, busy, 1);
            checkOutput({tag, "/done_early"}, done, 0);
            in_A = 8'($urandom);
            in_B = 8'($urandom);
            sel  = 4'($urandom);
            if (intrude && i == 2) begin
                start = 1'b1;
                sel   = OP_ADD;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (upd) begin
            exp_res = res;
            exp_n   = (res >= 128);
            exp_z   = (res == 0);
            exp_c   = c;
            exp_v   = v;
        end
        checkOutput({tag, "/done"}, done, 1);
        checkOutput({tag, "/busy_end"}, busy, 0);
        checkState(tag);
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        checkOutput({tag, "/done_idle"}, done, 0);
        checkOutput({tag, "/busy_idle"}, busy, 0);
    endtask

    task automatic clearModel();
        exp_res = 0;
        exp_n   = 1'b0;
        exp_z   = 1'b0;
        exp_c   = 1'b0;
        exp_v   = 1'b0;
    endtask

    // Start a shift, then reset it after one busy cycle and hold rst for 'hold' edges.
    task automatic abortShift(input int op, input int a, input int b, input int hold,
                              input string tag);
        start = 1'b1;
        sel   = 4'(op);
        in_A  = 8'(a);
        in_B  = 8'(b);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "/busy"}, busy, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        clearModel();
        checkOutput({tag, "/done"}, done, 0);
        checkOutput({tag, "/busy_reset"}, busy, 0);
        checkState(tag);
        idleCycle(tag);
    endtask

    initial begin
`ifdef ALU_SEQ_CARRY_EN
        carry_en = 1'b1;
`else
        carry_en = 1'b0;
`endif
        clearModel();
        rst   = 1'b1;
        start = 1'b0;
        sel   = '0;
        in_A  = '0;
        in_B  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset/done", done, 0);
        checkOutput("reset/busy", busy, 0);
        checkState("reset");

        applyStimulus(OP_ADD, 'h7F, 'h01, 1'b0, "add_ovf");
        checkOutput("add_ovf/const", result, 'h80);
        applyStimulus(OP_SUB, 'h05, 'h05, 1'b0, "sub_zero");
        applyStimulus(OP_SUB, 'h03, 'h05, 1'b0, "sub_borrow");
        checkOutput("sub_borrow/const", result, 'hFE);
        applyStimulus(OP_ADC, 'h01, 'h01, 1'b0, "adc");
        checkOutput("adc/const", result, carry_en ? 'h03 : 'hFE);
        idleCycle("after_adc");

        applyStimulus(OP_SHL, 'h81, 3, 1'b0, "shl3");
        checkOutput("shl3/const", result, 'h08);
        applyStimulus(OP_SHR, 'h81, 1, 1'b0, "shr1");
        applyStimulus(OP_ASR, 'h80, 7, 1'b1, "asr7_intrude");
        checkOutput("asr7/const", result, 'hFF);
        applyStimulus(OP_SHL, 'hA5, 0, 1'b0, "shl0");
        applyStimulus(OP_NAND, 'hF0, 'h3C, 1'b0, "nand");
        applyStimulus(OP_NOP, 'h12, 'h34, 1'b0, "nop");
        applyStimulus(13, 'h00, 'h00, 1'b0, "reserved");
        applyStimulus(OP_MOV, 'h00, 'h00, 1'b0, "mov_zero");
        idleCycle("after_directed");

        applyStimulus(OP_OUT, 'h5A, 'h00, 1'b0, "prime_abort");
        abortShift(OP_ASR, 'h80, 7, 1, "abort_cycle2");
        applyStimulus(OP_OUT, 'hC3, 'h00, 1'b0, "prime_abort2");
        abortShift(OP_SHL, 'h33, 6, 2, "abort_hold2");

        applyStimulus(OP_MOV, 'h00, 'h77, 1'b0, "prime_rst_start");
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        sel   = OP_ADD;
        in_A  = 8'h01;
        in_B  = 8'h01;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        clearModel();
        checkOutput("rst_start/done", done, 0);
        checkState("rst_start");

        for (int k = 0; k < 60; k++) begin
            applyStimulus(int'($urandom_range(15)), int'($urandom_range(255)),
                          int'($urandom_range(255)), 1'($urandom), "random");
        end
        idleCycle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit datapath ALU. Operands and opcode are captured on a start/busy/done handshake. Results and N/Z/C/V flags are registered. Variable-distance shifts run as a multi-cycle iterative shifter. Sits between the register file read ports and the write-back mux of the CPU datapath; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, default 8: operand/result width, ≥ 4.
- `SHAMT_W`, default $clog2(WIDTH): shift-amount width, taken from `in_B[SHAMT_W-1:0]`.

- `clk`  in  1  Single clock; all state changes on rising edge.
- `rst`  in  1  Reset, synchronous, active-high.
- `start`  in  1  Request; accepted only when `busy`=0.
- `sel`  in  4  Opcode.
- `in_A`, `in_B`  in  WIDTH  Operands; sampled only at the accept edge.
- `result`  out  WIDTH  Registered result.
- `N`, `Z`, `C`, `V`  out  1 each  Registered flags.
- `busy`  out  1  High while a shift is in progress.
- `done`  out  1  One-cycle pulse when a result commits.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (A−B)
  - 3 NAND
  - 4 SHL (logical, by shamt)
  - 5 SHR (logical, by shamt)
  - 6 OUT (pass A)
  - 7 IN (result 0)
  - 8 MOV (pass B)
  - 9 ASR (arithmetic right, by shamt)
  - 10 ADC (A+B+C)
  - 11–15 are treated as NOP.
- FSM states: IDLE, SHIFT.
  - IDLE + `start`, non-shift op: commit at the accept edge; stay in IDLE.
  - IDLE + `start`, shift op with shamt=0: commit A unchanged at the accept edge.
  - IDLE + `start`, shift op with shamt>0: load working register = A and count = shamt; go to SHIFT.
  - SHIFT: each edge shifts one bit and decrements count. The edge where count goes 1→0 performs the last shift, commits, and returns to IDLE.
- A commit updates `result`, updates the flags, and pulses `done`. NOP/reserved ops pulse `done` and leave `result` and the flags unchanged.
- Flags on commit:
  - N = result[WIDTH-1]; Z = (result == 0).
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB: C = borrow (A < B unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out (0 if shamt = 0); V = 0.
  - Logic/pass ops (NAND, OUT, IN, MOV): C = V = 0.
- Arithmetic is modulo 2^WIDTH; the carry is the (WIDTH+1)th bit.
- `start` while `busy` is ignored (no queueing). Operand changes during SHIFT have no effect.

## Timing
- Reset values: `result`=0, N=Z=C=V=0, `busy`=0, `done`=0, state IDLE.
- Single-cycle ops: `start` high in cycle t → `result`/flags/`done` valid in cycle t+1.
- Shift by n>0: `busy` is high in cycles t+1..t+n. `done` and the result are valid in cycle t+n+1, when `busy` is already 0. A new `start` is accepted in that same cycle.
- Back-to-back: single-cycle ops may be issued every cycle, giving `done` every cycle.
- `rst` mid-shift aborts the operation. Outputs return to reset values in the next cycle; no `done` is produced.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- `ALU_SEQ_CARRY_EN` defined: C/V computed as above; ADC implemented.
- Not defined: C and V held at 0; ADC decodes as NOP.
- N, Z and shifts are unaffected by the macro.

## Structure
- Shared package `alu_pkg`: opcode enum (`OP_NOP`…`OP_ADC`), FSM state enum, flag-index constants.
- Sub-module `alu_shift_iter` holds the working register, counter, direction/arith mode, and the last-out bit. It has a load/step/last interface to the top-level FSM.
- Combinational add/sub/logic stays in `alu_seq`.

## Test plan
- Reset: hold `rst` for 2 cycles mid-activity → `result`=0x00, N=Z=C=V=0, `busy`=0, `done`=0.
- ADD 0x7F+0x01 → next cycle `done`=1, `result`=0x80, N=1, Z=0, C=0, V=1.
- SUB:
  - 0x05−0x05 → `result`=0x00, Z=1, C=0, V=0.
  - Then 0x03−0x05 → `result`=0xFE, N=1, C=1, V=0.
- SHL A=0x81, B=3 → `busy` high for 3 cycles, `done` at t+4, `result`=0x08, C=0. Also SHR 0x81 by 1 → `result`=0x40, C=1, `done` at t+2.
- ASR 0x80 by 7 → `result`=0xFF, N=1. Pulse `start` with ADD during that shift → ignored, and the ASR result is unchanged. Reset asserted at shift cycle 2 → no `done`, `result`=0.
- With the macro defined, C=1, ADC 0x01+0x01 → `result`=0x03. Without the macro → `done` pulses, `result` and flags unchanged.
